// File: rtl/fft_pair_buffer_if.sv
// Streaming sample-in / butterfly-pair-out handshake bundle for fft_pair_buffer.
// slave is the buffer's view; master is the source/butterfly side.
interface fft_pair_buffer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 16
);
  localparam int unsigned IDXW = $clog2(N) - 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_r;
  logic [WIDTH-1:0] in_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] b_i;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;

  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, a_r, a_i, b_r, b_i, out_idx, out_last
  );

  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, a_r, a_i, b_r, b_i, out_idx, out_last
  );
endinterface

// File: rtl/fft_pair_buffer.sv
// Radix-2 DIF input stage: buffers the first half of each frame and emits
// (x[k], x[k+N/2]) pairs on a registered valid/ready port.
module fft_pair_buffer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 16
) (
  input logic              clk,
  input logic              rst_n,
  fft_pair_buffer_if.slave bus
);
  localparam int unsigned IDXW = $clog2(N) - 1;
  localparam int unsigned HALF = N / 2;
  localparam int unsigned DW   = 2 * WIDTH;
  localparam logic [IDXW-1:0] LAST = IDXW'(HALF - 1);

  typedef enum logic {FILL, PAIR} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   mem [HALF];
  logic [DW-1:0]   rd;
  logic            ready;
  logic            accept;
  logic            mem_we;
  logic            load;
  logic            pop;

  logic             out_valid_q;
  logic [WIDTH-1:0] a_r_q, a_i_q, b_r_q, b_i_q;
  logic [IDXW-1:0]  idx_q;
  logic             last_q;

  // State and pair counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FILL writes only mem, so a pair still held in the output register survives
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b1;
    accept  = 1'b0;
    mem_we  = 1'b0;
    load    = 1'b0;
    case (state_q)
      FILL: begin
        accept = bus.in_valid;
        mem_we = accept;
      end
      PAIR: begin
        ready  = !out_valid_q || bus.out_ready;
        accept = bus.in_valid && ready;
        load   = accept;
      end
      default: ;
    endcase
    if (accept) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        state_d = (state_q == FILL) ? PAIR : FILL;
      end else begin
        cnt_d = cnt_q + IDXW'(1);
      end
    end
  end

  assign pop = out_valid_q && bus.out_ready;
  assign rd  = mem[cnt_q];

  // First-half storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[cnt_q] <= {bus.in_r, bus.in_i};
  end

  // Output pair register; a load during a pop replaces the pair with no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      a_r_q       <= '0;
      a_i_q       <= '0;
      b_r_q       <= '0;
      b_i_q       <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      a_r_q       <= rd[DW-1:WIDTH];
      a_i_q       <= rd[WIDTH-1:0];
      b_r_q       <= bus.in_r;
      b_i_q       <= bus.in_i;
      idx_q       <= cnt_q;
      last_q      <= (cnt_q == LAST);
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.a_r       = a_r_q;
  assign bus.a_i       = a_i_q;
  assign bus.b_r       = b_r_q;
  assign bus.b_i       = b_i_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
endmodule

// File: tb/tb_fft_pair_buffer.sv
// Scoreboard bench for fft_pair_buffer (N=8, WIDTH=16): stimulus pushes expected
// pairs, a negedge monitor pops and compares every presented/consumed pair.
module tb_fft_pair_buffer;
  localparam int WIDTH = 16;
  localparam int N     = 8;
  localparam int HALF  = N / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_pair_buffer_if #(.WIDTH(WIDTH), .N(N)) bus ();
  fft_pair_buffer #(.WIDTH(WIDTH), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] ar, ai, br, bi;
    logic [1:0]  idx;
    logic        last;
    int          acc;
  } pair_t;

  pair_t       q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  bit          chk_ready = 1'b0;
  bit          rnd_done = 1'b0;
  logic [15:0] mr[HALF];
  logic [15:0] mi[HALF];
  int          m_cnt = 0;
  int          n_pop = 0;
  int          n_lastpop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference pairing: keep first half, pair each second-half sample with x[k]
  function automatic void model_accept(input logic [15:0] r, input logic [15:0] i);
    pair_t p;
    if (m_cnt < HALF) begin
      mr[m_cnt] = r;
      mi[m_cnt] = i;
    end else begin
      p.ar   = mr[m_cnt-HALF];
      p.ai   = mi[m_cnt-HALF];
      p.br   = r;
      p.bi   = i;
      p.idx  = 2'(m_cnt - HALF);
      p.last = (m_cnt == N - 1);
      p.acc  = cyc;
      q.push_back(p);
    end
    m_cnt = (m_cnt + 1) % N;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] r, input logic [15:0] i);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_r     = r;
    bus.in_i     = i;
    @(negedge clk);
    if (chk_ready) chk("in_ready_cont", 64'(bus.in_ready), 64'd1);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) chk("send_timeout", 64'd0, 64'd1);
    else model_accept(r, i);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    idle(2);
  endtask

  // Monitor: latency on first presentation, stability while stalled, data on pop
  logic [15:0] h_ar, h_ai, h_br, h_bi;
  logic [1:0]  h_idx;
  logic        h_last;
  bit          prev_stall = 1'b0;

  always @(negedge clk) begin
    pair_t p;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (prev_stall) begin
          chk("stall_ab", {bus.a_r, bus.a_i, bus.b_r, bus.b_i}, {h_ar, h_ai, h_br, h_bi});
          chk("stall_idx_last", 64'({bus.out_idx, bus.out_last}), 64'({h_idx, h_last}));
        end else if (q.size() == 0) begin
          chk("unexpected_pair", 64'd1, 64'd0);
        end else begin
          chk("latency", 64'(cyc), 64'(q[0].acc + 1));
        end
        if (bus.out_ready && q.size() != 0) begin
          p = q.pop_front();
          chk("pair_ab", {bus.a_r, bus.a_i, bus.b_r, bus.b_i}, {p.ar, p.ai, p.br, p.bi});
          chk("pair_idx", 64'(bus.out_idx), 64'(p.idx));
          chk("pair_last", 64'(bus.out_last), 64'(p.last));
          n_pop++;
          if (bus.out_last) n_lastpop++;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      h_ar   = bus.a_r;
      h_ai   = bus.a_i;
      h_br   = bus.b_r;
      h_bi   = bus.b_i;
      h_idx  = bus.out_idx;
      h_last = bus.out_last;
    end
  end

  initial begin
    int          pops0, last0;
    logic [15:0] ext_r[N];
    logic [15:0] ext_i[N];
    ext_r = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000};
    ext_i = '{16'h7FFF, 16'hFFFF, 16'h8000, 16'hFFFE, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h8001};

    bus.in_valid  = 1'b0;
    bus.in_r      = '0;
    bus.in_i      = '0;
    bus.out_ready = 1'b1;
    idle(2);

    // Reset state
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_ab", {bus.a_r, bus.a_i, bus.b_r, bus.b_i}, 64'd0);
    chk("rst_idx_last", 64'({bus.out_idx, bus.out_last}), 64'd0);
    rst_n = 1'b1;
    idle(1);

    // Basic frame: pairs (1,5),(2,6),(3,7),(4,8)
    for (int i = 1; i <= N; i++) send(16'(i), 16'd0);
    drain();

    // Backpressure at k=1: (2,6) must hold while 7 waits
    for (int i = 1; i <= 5; i++) send(16'(i), 16'(i + 100));
    idle(3);
    bus.out_ready = 1'b0;
    send(16'd6, 16'd106);
    bus.in_valid = 1'b1;
    bus.in_r     = 16'd7;
    bus.in_i     = 16'd107;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_held_ab", {bus.a_r, bus.a_i, bus.b_r, bus.b_i}, {16'd2, 16'd102, 16'd6, 16'd106});
      chk("bp_held_idx", 64'(bus.out_idx), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(16'd7, 16'd107);
    send(16'd8, 16'd108);
    drain();

    // Three back-to-back frames with no input gaps
    pops0 = n_pop;
    last0 = n_lastpop;
    chk_ready = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) send(16'(f * 16 + i + 1), 16'(f + 1));
    chk_ready = 1'b0;
    drain();
    chk("b2b_pairs", 64'(n_pop - pops0), 64'd12);
    chk("b2b_lasts", 64'(n_lastpop - last0), 64'd3);

    // Random input gaps and random out_ready
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 32; k++) begin
          if ($urandom_range(0, 1) == 1) idle(1);
          send(16'(16'h1000 + k), 16'(k * 3));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Reset while a pair of frame 2 is held
    for (int i = 0; i < 12; i++) send(16'(16'h2000 + i), 16'(i));
    idle(2);
    bus.out_ready = 1'b0;
    send(16'h200C, 16'd12);
    @(negedge clk);
    chk("prerst_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_ab", {bus.a_r, bus.a_i, bus.b_r, bus.b_i}, 64'd0);
    chk("midrst_idx_last", 64'({bus.out_idx, bus.out_last}), 64'd0);
    q.delete();
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(1);
    for (int i = 0; i < N; i++) send(16'(16'h3000 + i), 16'(16'h0300 + i));
    drain();

    // Extreme bit patterns pass through untouched
    for (int i = 0; i < N; i++) send(ext_r[i], ext_i[i]);
    drain();

    chk("final_queue", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
